// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_pkg
// Brief   : Shared types for the EX->MEM pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } ex_mem_ctrl_t;

    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_pipe_reg_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_buf
// Brief   : Generic 2-slot valid/ready register with a registered in_ready
//           and a synchronous flush of both slots.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         in_ready_q;

    logic w_accept;
    logic w_main_free;

    assign w_accept    = in_valid_i & in_ready_q;
    assign w_main_free = ~main_valid_q | out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            // Data regs keep their contents; only the valid bits matter.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = w_accept;
                if (w_accept) begin
                    main_data_d = in_data_i;
                end
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            // Registered ready cuts the combinational path from out_ready.
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q & rst_n;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_pipe_reg
// Brief   : EX->MEM pipeline register with skid buffer, flush and bubble
//           gating of the memory controls.
//           Optional macro EX_MEM_STALL_CNT_EN adds a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [DATA_W-1:0] in_payload,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mem_read,
    output logic              out_mem_write,
`ifdef EX_MEM_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic [DATA_W-1:0] out_payload
);

    localparam int PKT_W = EX_MEM_CTRL_W + DATA_W;

    ex_mem_ctrl_t     w_in_ctrl;
    ex_mem_ctrl_t     w_out_ctrl;
    logic [PKT_W-1:0] w_in_pkt;
    logic [PKT_W-1:0] w_out_pkt;

    assign w_in_ctrl.mem_read  = in_mem_read;
    assign w_in_ctrl.mem_write = in_mem_write;
    assign w_in_pkt            = {w_in_ctrl, in_payload};

    pipe_skid_buf #(
        .W (PKT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (reset_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (w_in_pkt),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (w_out_pkt)
    );

    assign w_out_ctrl    = w_out_pkt[PKT_W-1 -: EX_MEM_CTRL_W];
    assign out_payload   = w_out_pkt[DATA_W-1:0];
    // A bubble must never issue a load or store to memory.
    assign out_mem_read  = w_out_ctrl.mem_read  & out_valid;
    assign out_mem_write = w_out_ctrl.mem_write & out_valid;

`ifdef EX_MEM_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Flush does not clear the counter; it is a reset-only statistic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : ex_mem_pipe_reg
`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mem_pipe_reg
// Brief   : Directed self-checking bench for ex_mem_pipe_reg.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe_reg;

    localparam int DATA_W = 64;
`ifdef EX_MEM_STALL_CNT_EN
    localparam int CNT_W  = 4;
`else
    localparam int CNT_W  = 32;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_read;
    logic              in_mem_write;
    logic [DATA_W-1:0] in_payload;
    logic              out_valid;
    logic              out_ready;
    logic              out_mem_read;
    logic              out_mem_write;
    logic [DATA_W-1:0] out_payload;
`ifdef EX_MEM_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_payload    (in_payload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
`ifdef EX_MEM_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .out_payload   (out_payload)
    );

    // Decode never produces load+store together.
    always @(posedge clk) begin
        if (reset_n && in_valid && in_mem_read && in_mem_write)
            $error("illegal: in_mem_read and in_mem_write both set");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [DATA_W-1:0] p);
        in_valid     = v;
        in_mem_read  = rd;
        in_mem_write = wr;
        in_payload   = p;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_mem_read !== 1'b0 || out_mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: out_valid=%b in_ready=%b rd=%b wr=%b, want all 0",
                     out_valid, in_ready, out_mem_read, out_mem_write);
        end
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
        // Load an entry, then reset asynchronously mid-cycle.
        drive(1'b1, 1'b1, 1'b0, 64'h55);
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_mem_read !== 1'b1) begin
            n_err++; $display("FAIL reset_preload: out_valid=%b rd=%b want 1 1", out_valid, out_mem_read);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_mem_read !== 1'b0 || out_payload !== '0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: out_valid=%b rd=%b payload=%h in_ready=%b want 0 0 0 0",
                     out_valid, out_mem_read, out_payload, in_ready);
        end
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i[0], ~i[0], 64'h10 + 64'(i));
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_payload !== (64'h10 + 64'(i)) || in_ready !== 1'b1 ||
                out_mem_read !== i[0] || out_mem_write !== ~i[0]) begin
                n_err++;
                $display("FAIL stream_%0d: valid=%b payload=%h rdy=%b rd=%b wr=%b want 1 %h 1 %b %b",
                         i, out_valid, out_payload, in_ready, out_mem_read, out_mem_write,
                         64'h10 + 64'(i), i[0], ~i[0]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_end: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'hA0);
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_payload !== 64'hA0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first: valid=%b payload=%h rdy=%b want 1 a0 1", out_valid, out_payload, in_ready);
        end
        drive(1'b1, 1'b0, 1'b1, 64'hA1);
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_payload !== 64'hA0 || out_mem_read !== 1'b1) begin
            n_err++;
            $display("FAIL bp_full: rdy=%b payload=%h rd=%b want 0 a0 1", in_ready, out_payload, out_mem_read);
        end
        // Offered while full: must be ignored.
        drive(1'b1, 1'b0, 1'b0, 64'hAF);
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_payload !== 64'hA0) begin
            n_err++; $display("FAIL bp_hold: rdy=%b payload=%h want 0 a0", in_ready, out_payload);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_payload !== 64'hA1 || out_mem_write !== 1'b1 ||
            out_mem_read !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: valid=%b payload=%h wr=%b rd=%b rdy=%b want 1 a1 1 0 1",
                     out_valid, out_payload, out_mem_write, out_mem_read, in_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain: out_valid=%b payload=%h want empty", out_valid, out_payload);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'hB0); step();
        drive(1'b1, 1'b0, 1'b1, 64'hB1); step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_payload !== 64'hB0) begin
            n_err++; $display("FAIL flush_setup: rdy=%b payload=%h want 0 b0", in_ready, out_payload);
        end
        // Force acceptance path for B2 to be visible if flush were ignored.
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 64'hB2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL flush_kill: valid=%b rdy=%b wr=%b want 0 1 0", out_valid, in_ready, out_mem_write);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_nothing_%0d: valid=%b payload=%h want empty", i, out_valid, out_payload);
            end
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 64'hC0);
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_mem_write !== 1'b1 || out_payload !== 64'hC0) begin
            n_err++;
            $display("FAIL bubble_store: valid=%b wr=%b payload=%h want 1 1 c0", out_valid, out_mem_write, out_payload);
        end
        drive(1'b0, 1'b0, 1'b1, 64'hC1);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || out_mem_write !== 1'b0 || out_mem_read !== 1'b0) begin
                n_err++;
                $display("FAIL bubble_gate_%0d: valid=%b wr=%b rd=%b want 0 0 0", i, out_valid, out_mem_write, out_mem_read);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

`ifdef EX_MEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (stall_cnt !== 4'd0) begin
            n_err++; $display("FAIL stall_reset: stall_cnt=%0d want 0", stall_cnt);
        end
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'hD0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (stall_cnt !== 4'd3) begin
            n_err++; $display("FAIL stall_count3: stall_cnt=%0d want 3", stall_cnt);
        end
        for (int i = 0; i < 17; i++) step();
        n_cmp++;
        if (stall_cnt !== 4'd15) begin
            n_err++; $display("FAIL stall_sat: stall_cnt=%0d want 15", stall_cnt);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_cmp++;
        if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_flush: stall_cnt=%0d valid=%b want 15 0", stall_cnt, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
`ifdef EX_MEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ex_mem_pipe_reg
`default_nettype wire
